button_conditioner: RTL

Input front end of the sudoku design. Conditions the seven raw board buttons (original_up/down/left/right/start/a/b_button) before the game FSM uses them. Each button passes through a 2-FF synchronizer and a debouncer. The block then emits a one-cycle press pulse per button, plus auto-repeat pulses for the four direction buttons. It sits directly between the top-level button pins and the game/cursor controller inside top.

---
 rtl/button_conditioner_pkg.sv | 38 +++
 rtl/button_conditioner_debouncer.sv | 117 +++++++++++
 rtl/button_conditioner.sv | 66 ++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// sudoku_input_defs
//   Definitions shared by the sudoku button front end.
//   - Button index constants. These fix the bit order of the press/held
//     vectors: [6:0] = {b, a, start, right, left, down, up}.
//   - The per-button polarity mask. A 1 marks a button whose raw pin is
//     active-low (idle high).
//   - Default timing constants for a 50 MHz system clock.
//   - Small helpers that size the counters.
package sudoku_input_defs;

  localparam int NUM_BUTTONS = 7;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_START = 4;
  localparam int BTN_A     = 5;
  localparam int BTN_B     = 6;

  // The d-pad pins idle high. start/a/b idle low.
  localparam logic [NUM_BUTTONS-1:0] ACTIVE_LOW_MASK = 7'b0001111;

  // 10 ms debounce, 0.5 s until the first repeat, then one repeat every 0.1 s.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for a terminal count of v. It is never narrower than 1 bit.
  function automatic int cnt_width(input int v);
    return $clog2(max2(v, 2));
  endfunction

endpackage

// File: rtl/button_conditioner_debouncer.sv
// button_debouncer
//   Conditions one raw button. The path is:
//   2-FF synchronizer -> debouncer -> registered press pulse, plus an
//   optional auto-repeat.
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous reset, active low
//     raw    in   raw pin level. Its polarity is set by ACTIVE_LOW.
//     press  out  one-cycle pulse on a debounced press and on each repeat
//     held   out  debounced pressed level (1 = pressed)
module button_debouncer
  import sudoku_input_defs::*;
#(
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press,
  output logic held
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  // Setting REPEAT_DELAY to 0 turns auto-repeat off even on a d-pad button.
  localparam bit REP_ON = REPEAT_EN && (REPEAT_DELAY != 0);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rep_cnt;
  logic          rep_first;

  logic          sample;
  logic          differ;
  logic          commit;
  logic          rise;
  logic          fall;
  logic          rep_hit;

  // The synchronizer resets to the idle pin level. Releasing reset therefore
  // never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Everything after the synchronizer works in the "pressed = 1" domain.
  // The terminal compare fires on the last cycle of a run of differing
  // samples, so the counter tops out at DEBOUNCE_CYCLES-1 and never wraps.
  always_comb begin
    sample  = sync2 ^ ACTIVE_LOW;
    differ  = (sample != stable);
    commit  = differ && (db_cnt == DB_LAST);
    rise    = commit && sample;
    fall    = commit && !sample;
    rep_hit = REP_ON && stable && !fall &&
              (rep_cnt == (rep_first ? DELAY_LAST : PERIOD_LAST));
  end

  // Debouncer. Every sample that matches the accepted level restarts the
  // count, so each bounce begins a new qualification window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (!differ) begin
      db_cnt <= '0;
    end else if (commit) begin
      stable <= sample;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press and repeat pulses. The repeat counter is zeroed on the press edge
  // and counts only while the button is held. When it reaches the current
  // target it reloads to 0 and switches to the shorter period. A release
  // commit on the same edge as a repeat hit suppresses that pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press     <= 1'b0;
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      press <= rise || rep_hit;
      if (!REP_ON || rise || fall || !stable) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (rep_hit) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign held = stable;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Front end for the seven sudoku board buttons. Each button is synchronized
//   and debounced on its own path. The block then emits one-cycle press
//   pulses. The four direction buttons also auto-repeat while they are held.
//   Ports:
//     clk                    in   system clock
//     reset                  in   asynchronous reset, active low
//     original_up_button     in   raw, active low
//     original_down_button   in   raw, active low
//     original_left_button   in   raw, active low
//     original_right_button  in   raw, active low
//     original_start_button  in   raw, active high
//     original_a_button      in   raw, active high
//     original_b_button      in   raw, active high
//     press[6:0]             out  press/repeat pulses, bit order {b,a,start,right,left,down,up}
//     held[6:0]              out  debounced pressed levels, same bit order
module button_conditioner
  import sudoku_input_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       original_up_button,
  input  logic       original_down_button,
  input  logic       original_left_button,
  input  logic       original_right_button,
  input  logic       original_start_button,
  input  logic       original_a_button,
  input  logic       original_b_button,
  output logic [6:0] press,
  output logic [6:0] held
);

  logic [NUM_BUTTONS-1:0] raw;

  assign raw[BTN_UP]    = original_up_button;
  assign raw[BTN_DOWN]  = original_down_button;
  assign raw[BTN_LEFT]  = original_left_button;
  assign raw[BTN_RIGHT] = original_right_button;
  assign raw[BTN_START] = original_start_button;
  assign raw[BTN_A]     = original_a_button;
  assign raw[BTN_B]     = original_b_button;

  // The buttons are fully independent, so simultaneous presses give
  // simultaneous pulses with no priority between them. Only the d-pad
  // indices (up to BTN_RIGHT) get auto-repeat.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[i]),
      .REPEAT_EN       (i <= BTN_RIGHT),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .press (press[i]),
      .held  (held[i])
    );
  end

endmodule
